// File: rtl/sram_arbiter_pkg.sv
// Shared op codes, arbiter state encodings and command types for the SRAM arbiter.
// MEM_* values mirror the memory-op encoding used by the pipeline and sram_control.
package sram_arbiter_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LW  = 4'd1;
  localparam logic [3:0] MEM_LB  = 4'd2;
  localparam logic [3:0] MEM_LBU = 4'd3;
  localparam logic [3:0] MEM_LH  = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SW  = 4'd6;
  localparam logic [3:0] MEM_SB  = 4'd7;
  localparam logic [3:0] MEM_SH  = 4'd8;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_DATA = 2'd1;
  localparam logic [1:0] ARB_INST = 2'd2;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [19:0] addr;
    logic [31:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one sram_control port between instruction fetch and data access.
// Holds the granted op until success, then forces an idle cycle and pulses done to the winner.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [19:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_done_o,
  input  logic        data_req_i,
  input  logic [3:0]  data_op_i,
  input  logic [19:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_done_o,
  output logic [3:0]  ramOp_o,
  output logic [19:0] ramAddr_o,
  output logic [31:0] storeData_o,
  input  logic [31:0] loadData_i,
  input  logic        success_i,
  output logic        stall_o
);

  logic [1:0] state;
  grant_t     last_grant;
  logic       inst_pend;
  logic       data_pend;
  logic       grant_data;
  logic       grant_inst;
  ram_cmd_t   cmd;

  // Masking with done keeps a request that is still high in its own done cycle from being re-granted.
  assign inst_pend = inst_req_i & ~inst_done_o;
  assign data_pend = data_req_i & ~data_done_o & (data_op_i != MEM_NOP);

  assign stall_o = (inst_req_i & ~inst_done_o) | (data_req_i & ~data_done_o);

  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    cmd        = '0;
    if (state == ARB_IDLE) begin
      if (data_pend && (!inst_pend || DATA_FIRST || (last_grant == GRANT_INST))) begin
        grant_data = 1'b1;
      end else if (inst_pend) begin
        grant_inst = 1'b1;
      end
    end
    if (grant_data) begin
      cmd.op    = data_op_i;
      cmd.addr  = data_addr_i;
      cmd.wdata = data_wdata_i;
    end else if (grant_inst) begin
      cmd.op    = MEM_LW;
      cmd.addr  = inst_addr_i;
      cmd.wdata = 32'd0;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      last_grant   <= GRANT_INST;
      ramOp_o      <= MEM_NOP;
      ramAddr_o    <= 20'd0;
      storeData_o  <= 32'd0;
      inst_data_o  <= 32'd0;
      data_rdata_o <= 32'd0;
      inst_done_o  <= 1'b0;
      data_done_o  <= 1'b0;
    end else begin
      inst_done_o <= 1'b0;
      data_done_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_data || grant_inst) begin
            ramOp_o     <= cmd.op;
            ramAddr_o   <= cmd.addr;
            storeData_o <= cmd.wdata;
            state       <= grant_data ? ARB_DATA : ARB_INST;
            last_grant  <= grant_data ? GRANT_DATA : GRANT_INST;
          end
        end
        ARB_DATA: begin
          if (success_i) begin
            data_rdata_o <= loadData_i;
            data_done_o  <= 1'b1;
            ramOp_o      <= MEM_NOP;
            state        <= ARB_IDLE;
          end
        end
        ARB_INST: begin
          if (success_i) begin
            inst_data_o <= loadData_i;
            inst_done_o <= 1'b1;
            ramOp_o     <= MEM_NOP;
            state       <= ARB_IDLE;
          end
        end
        default: begin
          ramOp_o <= MEM_NOP;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a data-first instance and a round-robin instance,
// each driving a small sram_control model that raises success three cycles into an access.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic clk50 = 1'b0;
  logic rst;
  always #5 clk50 = ~clk50;

  int n_cmp = 0;
  int n_bad = 0;

  // data-first instance
  logic        inst_req, data_req, inst_done, data_done, success, stall;
  logic [19:0] inst_addr, data_addr, ram_addr;
  logic [3:0]  data_op, ram_op;
  logic [31:0] inst_data, data_wdata, data_rdata, store_data, load_data;
  int          cnt;
  int          extra_wait;
  logic        force_succ;

  // round-robin instance
  logic        r_inst_req, r_data_req, r_inst_done, r_data_done, r_success, r_stall;
  logic [19:0] r_inst_addr, r_data_addr, r_ram_addr;
  logic [3:0]  r_data_op, r_ram_op;
  logic [31:0] r_inst_data, r_data_wdata, r_data_rdata, r_store_data, r_load_data;
  int          r_cnt;

  sram_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk50(clk50), .rst(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_data_o(inst_data), .inst_done_o(inst_done),
    .data_req_i(data_req), .data_op_i(data_op), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata), .data_done_o(data_done),
    .ramOp_o(ram_op), .ramAddr_o(ram_addr), .storeData_o(store_data),
    .loadData_i(load_data), .success_i(success), .stall_o(stall)
  );

  sram_arbiter #(.DATA_FIRST(1'b0)) dut_rr (
    .clk50(clk50), .rst(rst),
    .inst_req_i(r_inst_req), .inst_addr_i(r_inst_addr), .inst_data_o(r_inst_data), .inst_done_o(r_inst_done),
    .data_req_i(r_data_req), .data_op_i(r_data_op), .data_addr_i(r_data_addr), .data_wdata_i(r_data_wdata),
    .data_rdata_o(r_data_rdata), .data_done_o(r_data_done),
    .ramOp_o(r_ram_op), .ramAddr_o(r_ram_addr), .storeData_o(r_store_data),
    .loadData_i(r_load_data), .success_i(r_success), .stall_o(r_stall)
  );

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return (a == 20'h00010) ? 32'hDEADBEEF : {12'hC00, a};
  endfunction

  // Controller model: success in the third cycle an op is on the bus (later when extra_wait > 0).
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) cnt <= 0;
    else if (ram_op == MEM_NOP || success) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign success   = ((ram_op != MEM_NOP) && (cnt == 2 + extra_wait)) || force_succ;
  assign load_data = mem_word(ram_addr);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) r_cnt <= 0;
    else if (r_ram_op == MEM_NOP || r_success) r_cnt <= 0;
    else r_cnt <= r_cnt + 1;
  end
  assign r_success   = (r_ram_op != MEM_NOP) && (r_cnt == 2);
  assign r_load_data = mem_word(r_ram_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic settle();
    @(negedge clk50);
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = '0; data_req = 0; data_op = MEM_NOP; data_addr = '0; data_wdata = '0;
    r_inst_req = 0; r_inst_addr = '0; r_data_req = 0; r_data_op = MEM_NOP; r_data_addr = '0; r_data_wdata = '0;
    extra_wait = 0; force_succ = 1'b0;

    tick(); settle();
    check_eq("rst_ramop", 32'(ram_op), 32'(MEM_NOP));
    check_eq("rst_ramaddr", 32'(ram_addr), 32'd0);
    check_eq("rst_store", store_data, 32'd0);
    check_eq("rst_idata", inst_data, 32'd0);
    check_eq("rst_drdata", data_rdata, 32'd0);
    check_eq("rst_dones", {30'd0, inst_done, data_done}, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    $display("[txn] reset state checked");
    tick(); rst = 1'b0;

    // Single LW, request held through its done cycle
    tick(); data_req = 1; data_op = MEM_LW; data_addr = 20'h00010;
    settle();
    check_eq("lw_c0_stall", 32'(stall), 32'd1);
    check_eq("lw_c0_ramop", 32'(ram_op), 32'(MEM_NOP));
    tick(); settle();
    check_eq("lw_c1_ramop", 32'(ram_op), 32'(MEM_LW));
    check_eq("lw_c1_addr", 32'(ram_addr), 32'h00010);
    repeat (2) tick(); settle();
    check_eq("lw_c3_done", 32'(data_done), 32'd0);
    tick(); settle();
    check_eq("lw_c4_done", 32'(data_done), 32'd1);
    check_eq("lw_c4_rdata", data_rdata, 32'hDEADBEEF);
    check_eq("lw_c4_ramop", 32'(ram_op), 32'(MEM_NOP));
    check_eq("lw_c4_stall", 32'(stall), 32'd0);
    tick(); data_req = 0; data_op = MEM_NOP;
    settle();
    check_eq("held_c5_ramop", 32'(ram_op), 32'(MEM_NOP));
    check_eq("held_c5_done", 32'(data_done), 32'd0);
    check_eq("held_c5_rdata", data_rdata, 32'hDEADBEEF);
    $display("[txn] LW @0x00010 rdata=0x%08h", data_rdata);

    // Simultaneous SW and fetch, data wins
    tick();
    data_req = 1; data_op = MEM_SW; data_addr = 20'h00004; data_wdata = 32'h12345678;
    inst_req = 1; inst_addr = 20'h00100;
    settle();
    check_eq("sim_c0_stall", 32'(stall), 32'd1);
    tick(); settle();
    check_eq("sim_c1_ramop", 32'(ram_op), 32'(MEM_SW));
    check_eq("sim_c1_addr", 32'(ram_addr), 32'h00004);
    check_eq("sim_c1_store", store_data, 32'h12345678);
    repeat (3) tick(); settle();
    check_eq("sim_c4_ddone", 32'(data_done), 32'd1);
    check_eq("sim_c4_ramop", 32'(ram_op), 32'(MEM_NOP));
    check_eq("sim_c4_stall", 32'(stall), 32'd1);
    tick(); data_req = 0; data_op = MEM_NOP;
    settle();
    check_eq("sim_c5_ramop", 32'(ram_op), 32'(MEM_LW));
    check_eq("sim_c5_addr", 32'(ram_addr), 32'h00100);
    check_eq("sim_c5_store", store_data, 32'd0);
    repeat (3) tick(); settle();
    check_eq("sim_c8_idone", 32'(inst_done), 32'd1);
    check_eq("sim_c8_idata", inst_data, 32'hC0000100);
    check_eq("sim_c8_stall", 32'(stall), 32'd0);
    tick(); inst_req = 0;
    settle();
    check_eq("sim_c9_idone", 32'(inst_done), 32'd0);
    $display("[txn] SW @0x00004 then fetch @0x00100 idata=0x%08h", inst_data);

    // Fetch only: stall profile
    tick(); inst_req = 1; inst_addr = 20'h00200;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_eq($sformatf("stall_c%0d", k), 32'(stall), 32'd1);
      tick();
    end
    settle();
    check_eq("stall_c4", 32'(stall), 32'd0);
    check_eq("fetch_c4_done", 32'(inst_done), 32'd1);
    check_eq("fetch_c4_idata", inst_data, 32'hC0000200);
    tick(); inst_req = 0;
    $display("[txn] fetch @0x00200 idata=0x%08h", inst_data);

    // Late success: arbiter keeps the op on the bus until it arrives
    extra_wait = 2;
    tick(); data_req = 1; data_op = MEM_LW; data_addr = 20'h00020;
    repeat (4) tick(); settle();
    check_eq("late_c4_done", 32'(data_done), 32'd0);
    check_eq("late_c4_ramop", 32'(ram_op), 32'(MEM_LW));
    repeat (2) tick(); settle();
    check_eq("late_c6_done", 32'(data_done), 32'd1);
    check_eq("late_c6_rdata", data_rdata, 32'hC0000020);
    tick(); data_req = 0; data_op = MEM_NOP; extra_wait = 0;
    $display("[txn] late-success LW @0x00020 rdata=0x%08h", data_rdata);

    // success while idle is ignored
    tick(); force_succ = 1'b1;
    settle();
    tick(); force_succ = 1'b0;
    settle();
    check_eq("idle_succ_dones", {30'd0, inst_done, data_done}, 32'd0);
    check_eq("idle_succ_rdata", data_rdata, 32'hC0000020);
    check_eq("idle_succ_idata", inst_data, 32'hC0000200);
    $display("[txn] idle success pulse ignored");

    // Reset in cycle 2 of an LW, request stays high
    tick(); data_req = 1; data_op = MEM_LW; data_addr = 20'h00010;
    tick();
    tick(); rst = 1'b1;
    settle();
    check_eq("rmid_ramop", 32'(ram_op), 32'(MEM_NOP));
    check_eq("rmid_addr", 32'(ram_addr), 32'd0);
    check_eq("rmid_rdata", data_rdata, 32'd0);
    check_eq("rmid_idata", inst_data, 32'd0);
    check_eq("rmid_stall", 32'(stall), 32'd1);
    tick(); rst = 1'b0;
    settle();
    check_eq("rrel_c0_ramop", 32'(ram_op), 32'(MEM_NOP));
    tick(); settle();
    check_eq("rrel_c1_ramop", 32'(ram_op), 32'(MEM_LW));
    repeat (3) tick(); settle();
    check_eq("rrel_c4_done", 32'(data_done), 32'd1);
    check_eq("rrel_c4_rdata", data_rdata, 32'hDEADBEEF);
    tick(); data_req = 0; data_op = MEM_NOP;
    $display("[txn] reset mid-access, restarted LW rdata=0x%08h", data_rdata);

    // Round-robin: both ports request continuously for four accesses
    tick();
    r_data_req = 1; r_data_op = MEM_LBU; r_data_addr = 20'h00030;
    r_inst_req = 1; r_inst_addr = 20'h00040;
    for (int a = 0; a < 4; a++) begin
      tick(); settle();
      check_eq($sformatf("rr_g%0d_op", a), 32'(r_ram_op), (a % 2 == 0) ? 32'(MEM_LBU) : 32'(MEM_LW));
      check_eq($sformatf("rr_g%0d_addr", a), 32'(r_ram_addr), (a % 2 == 0) ? 32'h00030 : 32'h00040);
      repeat (3) tick();
    end
    r_data_req = 0; r_data_op = MEM_NOP; r_inst_req = 0;
    settle();
    check_eq("rr_last_idone", 32'(r_inst_done), 32'd1);
    check_eq("rr_last_idata", r_inst_data, 32'hC0000040);
    check_eq("rr_last_rdata", r_data_rdata, 32'hC0000030);
    $display("[txn] round-robin alternation data,inst,data,inst");

    // Round-robin tie after a data-only access: fetch must win
    tick(); r_data_req = 1; r_data_op = MEM_LB; r_data_addr = 20'h00050;
    repeat (4) tick(); settle();
    check_eq("rr_lb_done", 32'(r_data_done), 32'd1);
    check_eq("rr_lb_rdata", r_data_rdata, 32'hC0000050);
    tick(); r_data_req = 0; r_data_op = MEM_NOP;
    tick();
    r_data_req = 1; r_data_op = MEM_SH; r_data_addr = 20'h00060; r_data_wdata = 32'hAAAA5555;
    r_inst_req = 1; r_inst_addr = 20'h00070;
    tick(); settle();
    check_eq("rr_tie_op", 32'(r_ram_op), 32'(MEM_LW));
    check_eq("rr_tie_addr", 32'(r_ram_addr), 32'h00070);
    repeat (3) tick(); r_inst_req = 0;
    settle();
    check_eq("rr_tie_idone", 32'(r_inst_done), 32'd1);
    tick(); settle();
    check_eq("rr_sh_op", 32'(r_ram_op), 32'(MEM_SH));
    check_eq("rr_sh_addr", 32'(r_ram_addr), 32'h00060);
    check_eq("rr_sh_store", r_store_data, 32'hAAAA5555);
    repeat (3) tick(); settle();
    check_eq("rr_sh_done", 32'(r_data_done), 32'd1);
    tick(); r_data_req = 0; r_data_op = MEM_NOP;
    $display("[txn] round-robin tie after data access granted fetch first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single `sram_control` port between instruction fetch and the MEM-stage data access. The arbiter grants one requester at a time and holds its operation on the controller until `success`. It then forces one idle cycle so the controller's FSM returns to IDLE, returns read data and a one-cycle done pulse to the winner, and drives a pipeline stall while any request is outstanding.

## Interface
- `DATA_FIRST`, default 1: 1 = data port always wins ties; 0 = round-robin, last-granted port loses ties.
- `clk50` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_req_i` in 1: fetch request, held high until `inst_done_o`.
- `inst_addr_i` in 20: fetch word address.
- `inst_data_o` out 32: fetched word, valid while `inst_done_o`=1 and held until next fetch completes.
- `inst_done_o` out 1: one-cycle completion pulse.
- `data_req_i` in 1: data request, held until `data_done_o`.
- `data_op_i` in 4: `MEM_*` code (LW/LB/LBU/LH/LHU/SW/SB/SH).
- `data_addr_i` in 20: data word address.
- `data_wdata_i` in 32: store data.
- `data_rdata_o` out 32: load result from controller; held like `inst_data_o`.
- `data_done_o` out 1: one-cycle completion pulse, loads and stores.
- `ramOp_o` out 4: op to controller; 0 = idle.
- `ramAddr_o` out 20: address to controller.
- `storeData_o` out 32: store data to controller.
- `loadData_i` in 32: controller load data.
- `success_i` in 1: controller completion.
- `stall_o` out 1: pipeline hold.

## Operation
- States:
  - IDLE: `ramOp_o`=0.
  - DATA: serving the data port.
  - INST: serving fetch.
- IDLE, effective requests: `inst_req_i & ~inst_done_o` and `data_req_i & ~data_done_o & (data_op_i != 0)`.
  - The done mask stops re-granting a request in its own done cycle.
- Grant, DATA_FIRST=1: data beats inst.
- Grant, DATA_FIRST=0: on a tie, the port not granted last wins. `last_grant` resets to INST, so data wins the first tie.
- On grant, register the downstream values:
  - data: `ramOp_o`=`data_op_i`, `ramAddr_o`=`data_addr_i`, `storeData_o`=`data_wdata_i`.
  - inst: `ramOp_o`=`MEM_LW`, `ramAddr_o`=`inst_addr_i`, `storeData_o`=0.
- DATA/INST: hold all downstream registers constant; ignore requester input changes.
- On `success_i`=1:
  - latch `loadData_i` into the winner's data register (data stores also latch; value is don't-care).
  - pulse that port's done.
  - clear `ramOp_o` to 0 and return to IDLE.
- `stall_o` = `(inst_req_i & ~inst_done_o) | (data_req_i & ~data_done_o)`. Combinational; the only combinational output.
- Reset values:
  - state IDLE.
  - `ramOp_o`, `ramAddr_o`, `storeData_o`, `inst_data_o`, `data_rdata_o` all 0.
  - both done outputs 0.
- Reset mid-operation aborts the access immediately. The requester's request stays pending and is re-arbitrated after reset.
- `success_i` in IDLE is ignored.

## Timing
- Cycle 0: IDLE, request seen, grant registered.
- Cycles 1–3: controller runs IDLE→READ/WRITE→END; `success_i` is high in cycle 3.
- Cycle 4: arbiter IDLE, `ramOp_o`=0, done pulse high, data valid. The controller sees op=0 and returns to IDLE. A new grant may be taken in this cycle.
- Cycle 5: next access's op on the bus.
- Latency: request to done = 4 cycles. Back-to-back throughput = one access per 4 cycles.
- Both requests at cycle 0 with DATA_FIRST=1: data done at cycle 4, inst done at cycle 8.
- `success_i` arriving later than cycle 3: the arbiter waits indefinitely in DATA/INST; no timeout.

## Structure
- `MEM_*` op codes come from `defines.v`. Add to `defines.v`: `ARB_IDLE`/`ARB_DATA`/`ARB_INST` state encodings (2 bits) and `MEM_NOP` (4'b0).
- Single module, no sub-module. Grant logic is one combinational block.
- Instantiated between the pipeline (IF/MEM) and `sram_control`.

## Test plan
- Single LW: data_req, op=`MEM_LW`, addr=0x00010; model returns 0xDEADBEEF in cycle 3 → `data_done_o` pulse in cycle 4, `data_rdata_o`=0xDEADBEEF, `ramOp_o`=0 in cycle 4.
- Simultaneous requests, DATA_FIRST=1: data SW 0x12345678 @0x00004, fetch @0x00100 → `ramOp_o`=`MEM_SW` first, data done cycle 4, `ramOp_o`=`MEM_LW` addr 0x00100 cycle 5, inst done cycle 8.
- Round-robin, DATA_FIRST=0: both ports request continuously for 4 accesses → grants alternate data, inst, data, inst.
- Held request after done: requester keeps req high one cycle past done → no regrant; `ramOp_o` stays 0 that cycle.
- Reset mid-access: assert `rst` in cycle 2 of a data LW → all outputs 0 immediately; after release with req still high, access restarts and completes 4 cycles later.
- Stall: fetch pending, no data → `stall_o`=1 in cycles 0–3, 0 in cycle 4 (done cycle).
